// File: rtl/ct_spsram_ctrl_pkg.sv
// ct_spsram_ctrl_pkg: shared state type, default geometry and idle pin levels
// for the 512x22 single-port SRAM controller.
package ct_spsram_ctrl_pkg;
   typedef enum logic {ST_INIT, ST_RUN} state_e;
   localparam int CT_ADDR_W = 9;
   localparam int CT_DATA_W = 22;
   localparam int CT_DEPTH = 2 ** CT_ADDR_W;
   localparam int STARVE_W = 4;
   localparam logic CEN_IDLE = 1'b1;
   localparam logic GWEN_IDLE = 1'b1;
   localparam logic WEN_IDLE = 1'b1;
endpackage

// File: rtl/ct_spsram_ctrl_arb.sv
// ct_spsram_ctrl_arb: write-priority grant with read anti-starvation; reads
// win once they have been denied STARVE_MAX consecutive cycles.
module ct_spsram_ctrl_arb
   import ct_spsram_ctrl_pkg::*;
#(
   parameter int STARVE_MAX = 4
) (
   input  logic forever_cpuclk,
   input  logic cpurst,
   input  logic en,
   input  logic rd_req,
   input  logic wr_req,
   output logic rd_gnt,
   output logic wr_gnt
);
   logic [STARVE_W-1:0] starve_q;
   logic starved;
   assign starved = starve_q == STARVE_W'(STARVE_MAX);
   assign rd_gnt = en & rd_req & (~wr_req | starved);
   assign wr_gnt = en & wr_req & ~rd_gnt;
   // en is low in INIT and in the flush cycle, so entering INIT clears the count
   always_ff @(posedge forever_cpuclk)
      if (cpurst | ~en | ~rd_req | rd_gnt) starve_q <= '0;
      else if (!starved) starve_q <= starve_q + 1'b1;
endmodule

// File: rtl/ct_spsram_512x22_ctrl.sv
// ct_spsram_512x22_ctrl: init sweep, read/write arbitration and pin mux for one 512x22 SRAM.
// CT_SPSRAM_CTRL_INIT_EN enables the clearing sweep; otherwise INIT is one idle cycle.
module ct_spsram_512x22_ctrl
   import ct_spsram_ctrl_pkg::*;
#(
   parameter int ADDR_WIDTH = CT_ADDR_W,
   parameter int DATA_WIDTH = CT_DATA_W,
   parameter int STARVE_MAX = 4,
   parameter logic [DATA_WIDTH-1:0] INIT_VAL = '0
) (
   input  logic                  forever_cpuclk,
   input  logic                  cpurst,
   input  logic                  flush_req,
   output logic                  init_done,
   input  logic                  rd_req,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic                  rd_gnt,
   output logic                  rd_vld,
   output logic [DATA_WIDTH-1:0] rd_data,
   input  logic                  wr_req,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic [DATA_WIDTH-1:0] wr_mask,
   output logic                  wr_gnt,
   output logic [ADDR_WIDTH-1:0] sram_a,
   output logic                  sram_cen,
   output logic [DATA_WIDTH-1:0] sram_d,
   output logic                  sram_gwen,
   output logic [DATA_WIDTH-1:0] sram_wen,
   input  logic [DATA_WIDTH-1:0] sram_q
);
`ifdef CT_SPSRAM_CTRL_INIT_EN
   localparam bit SWEEP_EN = 1'b1;
`else
   localparam bit SWEEP_EN = 1'b0;
`endif
   localparam int DEPTH = 2 ** ADDR_WIDTH;
   state_e state_q, state_d;
   logic [ADDR_WIDTH-1:0] cnt_q, a_q;
   logic [DATA_WIDTH-1:0] d_q;
   logic rd_vld_q, sweep, sweep_last, en;
   assign init_done = ~cpurst & (state_q == ST_RUN);
   assign en = init_done & ~flush_req;
   assign sweep = SWEEP_EN & ~cpurst & (state_q == ST_INIT);
   assign sweep_last = ~SWEEP_EN | (cnt_q == ADDR_WIDTH'(DEPTH - 1));
   ct_spsram_ctrl_arb #(.STARVE_MAX(STARVE_MAX)) u_arb (
      .forever_cpuclk(forever_cpuclk),
      .cpurst        (cpurst),
      .en            (en),
      .rd_req        (rd_req),
      .wr_req        (wr_req),
      .rd_gnt        (rd_gnt),
      .wr_gnt        (wr_gnt)
   );
   always_ff @(posedge forever_cpuclk)
      if (cpurst) state_q <= ST_INIT;
      else state_q <= state_d;
   always_comb
      state_d = (state_q == ST_INIT) ? (sweep_last ? ST_RUN : ST_INIT)
                                     : (flush_req ? ST_INIT : ST_RUN);
   // a_q/d_q keep the last driven address/data so idle cycles do not toggle the pins
   always_ff @(posedge forever_cpuclk)
      if (cpurst) begin
         cnt_q <= '0;
         rd_vld_q <= 1'b0;
         a_q <= '0;
         d_q <= '0;
      end else begin
         cnt_q <= (state_q == ST_INIT) ? cnt_q + 1'b1 : '0;
         rd_vld_q <= rd_gnt;
         a_q <= sram_a;
         d_q <= sram_d;
      end
   always_comb begin
      sram_cen = (sweep | rd_gnt | wr_gnt) ? ~CEN_IDLE : CEN_IDLE;
      sram_gwen = (sweep | wr_gnt) ? ~GWEN_IDLE : GWEN_IDLE;
      sram_wen = sweep ? '0 : wr_gnt ? ~wr_mask : {DATA_WIDTH{WEN_IDLE}};
      sram_a = cpurst ? '0 : sweep ? cnt_q : wr_gnt ? wr_addr : rd_gnt ? rd_addr : a_q;
      sram_d = cpurst ? '0 : sweep ? INIT_VAL : wr_gnt ? wr_data : d_q;
      rd_vld = rd_vld_q & ~cpurst;
      rd_data = sram_q;
   end
endmodule

// File: tb/tb_ct_spsram_512x22_ctrl.sv
// tb_ct_spsram_512x22_ctrl: directed bench with a behavioural SRAM and a read-data scoreboard.
module tb_ct_spsram_512x22_ctrl;
`ifdef CT_SPSRAM_CTRL_INIT_EN
   localparam int INIT_CYC = 512;
   localparam logic [21:0] FLUSH_EXP = 22'h0;
`else
   localparam int INIT_CYC = 1;
   localparam logic [21:0] FLUSH_EXP = 22'h0007FF;
`endif
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic cpurst, flush_req, init_done, rd_req, rd_gnt, rd_vld, wr_req, wr_gnt;
   logic sram_cen, sram_gwen;
   logic [8:0] rd_addr, wr_addr, sram_a;
   logic [21:0] rd_data, wr_data, wr_mask, sram_d, sram_wen, sram_q;
   logic [21:0] mem [0:511];
   logic [21:0] exp_q [$];
   int total = 0, bad = 0;

   ct_spsram_512x22_ctrl dut (
      .forever_cpuclk(clk), .cpurst(cpurst), .flush_req(flush_req), .init_done(init_done),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_vld(rd_vld), .rd_data(rd_data),
      .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_mask(wr_mask), .wr_gnt(wr_gnt),
      .sram_a(sram_a), .sram_cen(sram_cen), .sram_d(sram_d), .sram_gwen(sram_gwen),
      .sram_wen(sram_wen), .sram_q(sram_q)
   );

   initial for (int i = 0; i < 512; i++) mem[i] = 22'h155555;
   always @(posedge clk)
      if (sram_cen === 1'b0) begin
         if (sram_gwen === 1'b0) begin
            for (int i = 0; i < 22; i++) if (!sram_wen[i]) mem[sram_a][i] <= sram_d[i];
         end else sram_q <= mem[sram_a];
      end

   always @(negedge clk)
      if (rd_vld === 1'b1) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL rd_vld_unexpected: got data %0h want no rd_vld", rd_data);
         end else begin
            logic [21:0] e;
            e = exp_q.pop_front();
            if (rd_data !== e) begin
               bad++;
               $display("FAIL rd_data: got %0h want %0h", rd_data, e);
            end
         end
      end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic r, input logic [8:0] ra, input logic w, input logic [8:0] wa,
                        input logic [21:0] wd, input logic [21:0] wm, input logic f);
      tick();
      rd_req = r; rd_addr = ra; wr_req = w; wr_addr = wa; wr_data = wd; wr_mask = wm; flush_req = f;
      #1;
   endtask

   task automatic sweep(input int n);
      for (int k = 0; k < n; k++) begin
         if (k > 0) tick();
         #1;
         chk("init_done_low", init_done, 0);
         chk("no_grant_init", {rd_gnt, wr_gnt}, 0);
`ifdef CT_SPSRAM_CTRL_INIT_EN
         chk("sweep_cen_gwen", {sram_cen, sram_gwen}, 0);
         chk("sweep_addr", sram_a, k);
         chk("sweep_wen", sram_wen, 0);
         chk("sweep_data", sram_d, 0);
`else
         chk("no_sweep_write", {sram_cen, sram_gwen}, 2'b11);
`endif
      end
   endtask

   task automatic chk_idle_reset();
      chk("rst_pins", {sram_cen, sram_gwen}, 2'b11);
      chk("rst_wen", sram_wen, 22'h3FFFFF);
      chk("rst_a_d", {sram_a, sram_d}, 0);
      chk("rst_outs", {init_done, rd_gnt, wr_gnt, rd_vld}, 0);
   endtask

   initial begin
      cpurst = 1; flush_req = 0; rd_req = 1; wr_req = 1;
      rd_addr = 9'h1; wr_addr = 9'h2; wr_data = 22'h3; wr_mask = 22'h3FFFFF;
      tick(); tick(); #1;
      chk_idle_reset();
      tick();
      cpurst = 0; rd_req = 0; wr_req = 0;
      sweep(INIT_CYC);
      tick(); #1;
      chk("init_done_high", init_done, 1);
      drive(0, 0, 1, 9'h05, 22'h000000, 22'h3FFFFF, 0);
      chk("wr_full_gnt", {wr_gnt, rd_gnt}, 2'b10);
      drive(0, 0, 1, 9'h05, 22'h3FFFFF, 22'h0007FF, 0);
      chk("wr_mask_gnt", {wr_gnt, rd_gnt}, 2'b10);
      chk("wr_mask_pins", {sram_cen, sram_gwen}, 0);
      chk("wr_mask_a", sram_a, 9'h05);
      chk("wr_mask_wen", sram_wen, 22'h3FF800);
      chk("wr_mask_d", sram_d, 22'h3FFFFF);
      drive(0, 0, 1, 9'h05, 22'h3FFFFF, 22'h000000, 0);
      chk("wr_zero_gnt", wr_gnt, 1);
      chk("wr_zero_pins", {sram_cen, sram_gwen, sram_wen}, {2'b00, 22'h3FFFFF});
      drive(1, 9'h05, 0, 0, 0, 0, 0);
      chk("rd_gnt", {rd_gnt, wr_gnt}, 2'b10);
      chk("rd_pins", {sram_cen, sram_gwen, sram_wen}, {2'b01, 22'h3FFFFF});
      chk("rd_a", sram_a, 9'h05);
      exp_q.push_back(22'h0007FF);
      drive(0, 0, 0, 0, 0, 0, 0);
      chk("rd_vld_next", rd_vld, 1);
      chk("idle_cen_gwen", {sram_cen, sram_gwen}, 2'b11);
      chk("idle_hold_a", sram_a, 9'h05);
      chk("idle_hold_d", sram_d, 22'h3FFFFF);
      for (int i = 0; i < 10; i++) begin
         drive(1, 9'h05, 1, 9'h10, 22'h2AAAAA, 22'h3FFFFF, 0);
         chk("starve_pattern", {rd_gnt, wr_gnt}, (i % 5 == 4) ? 2'b10 : 2'b01);
         if (i % 5 == 4) exp_q.push_back(22'h0007FF);
      end
      drive(0, 0, 0, 0, 0, 0, 0);
      drive(1, 9'h05, 0, 0, 0, 0, 1);
      chk("flush_no_gnt", {rd_gnt, wr_gnt, sram_cen}, 3'b001);
      for (int k = 0; k < INIT_CYC; k++) begin
         drive(1, 9'h05, 0, 0, 0, 0, 0);
         chk("flush_init_low", {init_done, rd_gnt}, 0);
      end
      drive(1, 9'h05, 0, 0, 0, 0, 0);
      chk("flush_done_rd", {init_done, rd_gnt}, 2'b11);
      exp_q.push_back(FLUSH_EXP);
      drive(0, 0, 0, 0, 0, 0, 0);
      chk("flush_rd_vld", rd_vld, 1);
      drive(1, 9'h05, 0, 0, 0, 0, 0);
      chk("pre_rst_rd_gnt", rd_gnt, 1);
      tick();
      cpurst = 1; rd_req = 0;
      #1;
      chk("rst_rd_vld_suppr", rd_vld, 0);
      chk_idle_reset();
      tick(); tick();
      cpurst = 0;
`ifdef CT_SPSRAM_CTRL_INIT_EN
      sweep(201);
      tick();
      cpurst = 1;
      #1;
      chk_idle_reset();
      tick(); tick();
      cpurst = 0;
      sweep(512);
`else
      sweep(1);
`endif
      tick(); #1;
      chk("reinit_done", init_done, 1);
      tick(); tick();
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_left: got %0d pending want 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
